// File: rtl/setup_menu_if.sv
// Types and bus interface for the keypad-driven setup menu.
// setup_menu_pkg holds the configuration and display packet types shared by DUT and controller.
package setup_menu_pkg;

  typedef struct packed {
    logic       status;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
  } pin_t;

  typedef struct packed {
    logic       bip_status;
    logic [6:0] bip_time;
    logic [6:0] tranca_aut_time;
    pin_t       master_pin;
    pin_t       pin1;
    pin_t       pin2;
    pin_t       pin3;
    pin_t       pin4;
  } setupPac_t;

  // Index n is display digit BCDn; 0xA shows blank.
  typedef logic [5:0][3:0] bcdPac_t;

endpackage

interface setup_menu_if;
  import setup_menu_pkg::*;

  logic       setup_on;
  setupPac_t  data_setup_old;
  logic       key_valid;
  logic [3:0] key_code;
  setupPac_t  data_setup_new;
  logic       setup_end;
  bcdPac_t    bcd_out;
  logic       bcd_enable;

  modport master (
    output setup_on, data_setup_old, key_valid, key_code,
    input  data_setup_new, setup_end, bcd_out, bcd_enable
  );

  modport slave (
    input  setup_on, data_setup_old, key_valid, key_code,
    output data_setup_new, setup_end, bcd_out, bcd_enable
  );

endinterface

// File: rtl/setup_menu.sv
// Keypad setup menu: walks eight configuration fields, validates entries, drives the display.
// Optional inactivity timeout enabled by defining SETUP_TIMEOUT_EN.
module setup_menu
  import setup_menu_pkg::*;
#(
  parameter int unsigned TIME_MIN = 5,
  parameter int unsigned TIME_MAX = 60,
  parameter int unsigned CLK_HZ   = 1000
) (
  input logic         clk,
  input logic         rst,
  setup_menu_if.slave bus
);

  if (CLK_HZ == 0 || TIME_MIN > TIME_MAX || TIME_MAX > 99) begin : g_param_check
    $error("setup_menu: invalid CLK_HZ/TIME_MIN/TIME_MAX");
  end

  typedef enum logic [1:0] {StIdle, StLoad, StEdit, StDone} state_e;

  state_e          state_q, state_d;
  setupPac_t       work_q, work_d;
  setupPac_t       out_q, out_d;
  logic [3:0]      field_q, field_d;
  logic [3:0][3:0] dig_q, dig_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            key_q, on_q;
  logic            key_stb, advance, reject, time_ok;
  logic [6:0]      time_val;
  pin_t            new_pin;

`ifdef SETUP_TIMEOUT_EN
  localparam int unsigned TmoLimit = 30 * CLK_HZ;
  logic [31:0] tmo_q, tmo_d;
`endif

  assign key_stb = bus.key_valid & ~key_q;

  // dig_q[0] is the first digit entered.
  assign time_val = (cnt_q == 3'd1) ? {3'b000, dig_q[0]}
                                    : 7'(dig_q[0]) * 7'd10 + {3'b000, dig_q[1]};
  assign time_ok  = (cnt_q == 3'd1 || cnt_q == 3'd2) &&
                    32'(time_val) >= TIME_MIN && 32'(time_val) <= TIME_MAX;
  assign new_pin  = '{status: 1'b1, digit1: dig_q[0], digit2: dig_q[1],
                      digit3: dig_q[2], digit4: dig_q[3]};

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    out_d   = out_q;
    field_d = field_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    advance = 1'b0;
    reject  = 1'b0;
`ifdef SETUP_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      StIdle: if (bus.setup_on && !on_q) state_d = StLoad;
      StLoad: begin
        work_d  = bus.data_setup_old;
        field_d = 4'd1;
        cnt_d   = 3'd0;
        err_d   = 1'b0;
`ifdef SETUP_TIMEOUT_EN
        tmo_d   = '0;
`endif
        state_d = bus.setup_on ? StEdit : StIdle;
      end
      StEdit: begin
        if (!bus.setup_on) begin
          state_d = StIdle;
        end else if (key_stb) begin
          err_d = 1'b0;
`ifdef SETUP_TIMEOUT_EN
          tmo_d = '0;
`endif
          if (bus.key_code <= 4'd9) begin
            if (cnt_q < 3'd4) begin
              dig_d[cnt_q[1:0]] = bus.key_code;
              cnt_d = cnt_q + 3'd1;
            end
          end else if (bus.key_code == 4'hB) begin
            cnt_d = 3'd0;
          end else if (bus.key_code == 4'hC) begin
            if (field_q >= 4'd5) begin
              advance = 1'b1;
              case (field_q)
                4'd5:    work_d.pin1.status = 1'b0;
                4'd6:    work_d.pin2.status = 1'b0;
                4'd7:    work_d.pin3.status = 1'b0;
                default: work_d.pin4.status = 1'b0;
              endcase
            end
          end else if (bus.key_code == 4'hA) begin
            if (cnt_q == 3'd0) begin
              advance = 1'b1;
            end else if (field_q == 4'd1) begin
              if (cnt_q == 3'd1 && dig_q[0] <= 4'd1) begin
                work_d.bip_status = dig_q[0][0];
                advance = 1'b1;
              end else begin
                reject = 1'b1;
              end
            end else if (field_q <= 4'd3) begin
              if (time_ok) begin
                if (field_q == 4'd2) work_d.bip_time = time_val;
                else                 work_d.tranca_aut_time = time_val;
                advance = 1'b1;
              end else begin
                reject = 1'b1;
              end
            end else if (cnt_q == 3'd4) begin
              advance = 1'b1;
              case (field_q)
                4'd4:    work_d.master_pin = new_pin;
                4'd5:    work_d.pin1 = new_pin;
                4'd6:    work_d.pin2 = new_pin;
                4'd7:    work_d.pin3 = new_pin;
                default: work_d.pin4 = new_pin;
              endcase
            end else begin
              reject = 1'b1;
            end
          end
          if (reject) begin
            cnt_d = 3'd0;
            err_d = 1'b1;
          end
          if (advance) begin
            cnt_d = 3'd0;
            if (field_q == 4'd8) begin
              state_d = StDone;
              out_d   = work_d;
            end else begin
              field_d = field_q + 4'd1;
            end
          end
        end
`ifdef SETUP_TIMEOUT_EN
        else if (tmo_q == TmoLimit - 1) begin
          // Inactivity: complete the session but publish the untouched configuration.
          out_d   = bus.data_setup_old;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
`endif
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      work_q  <= '0;
      out_q   <= '0;
      field_q <= 4'd1;
      dig_q   <= '0;
      cnt_q   <= 3'd0;
      err_q   <= 1'b0;
      key_q   <= 1'b0;
      on_q    <= 1'b0;
`ifdef SETUP_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      out_q   <= out_d;
      field_q <= field_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      key_q   <= bus.key_valid;
      on_q    <= bus.setup_on;
`ifdef SETUP_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign bus.setup_end      = (state_q == StDone);
  assign bus.data_setup_new = out_q;

  // Buffer is right-aligned: the most recent digit sits on BCD0.
  always_comb begin
    bus.bcd_out    = {6{4'hA}};
    bus.bcd_enable = 1'b0;
    if (state_q == StEdit) begin
      bus.bcd_enable = 1'b1;
      bus.bcd_out[5] = field_q;
      if (err_q) begin
        bus.bcd_out[3:0] = {4{4'hB}};
      end else begin
        case (cnt_q)
          3'd1: bus.bcd_out[0] = dig_q[0];
          3'd2: bus.bcd_out[1:0] = {dig_q[0], dig_q[1]};
          3'd3: bus.bcd_out[2:0] = {dig_q[0], dig_q[1], dig_q[2]};
          3'd4: bus.bcd_out[3:0] = {dig_q[0], dig_q[1], dig_q[2], dig_q[3]};
          default: ;
        endcase
      end
    end
  end

endmodule
